dequeue_agent_v0_1: RTL
=======================

DEQUEUE_AGENT_V0_1 -- requirements
Module: dequeue_agent_v0_1

Interface
REQ-001 Parameter QUEUE_NUM, default 5, number of output queues (NF0..NF3, CPU).
REQ-002 Parameter PIFO_WIDTH, default 32, root PIFO entry width: valid[31], rank[30:12], buffer_addr[11:0].
REQ-003 axis_aclk  input  1  single clock; all logic rising-edge.
REQ-004 axis_reset  input  1  reset, asynchronous, active-high.
REQ-005 s_axis_pifo_empty  input  QUEUE_NUM  per-queue PIFO empty.
REQ-006 s_axis_pifo_dout  input  QUEUE_NUM*PIFO_WIDTH  per-queue popped PIFO entry, queue q at [q*PIFO_WIDTH +: PIFO_WIDTH], valid one cycle after pop.
REQ-007 s_axis_buffer_empty  input  QUEUE_NUM  per-queue packet buffer empty.
REQ-008 s_axis_buffer_tlast  input  QUEUE_NUM  buffer word at read pointer is end of packet.
REQ-009 m_axis_tready  input  QUEUE_NUM  downstream port ready.
REQ-010 m_axis_ctl_pifo_out_en  output  QUEUE_NUM  one-hot PIFO pop pulse.
REQ-011 m_axis_ctl_buffer_rd_en  output  QUEUE_NUM  one-hot buffer read enable.
REQ-012 m_axis_buffer_rd_addr  output  12  start address of packet being read.
REQ-013 m_axis_tvalid  output  QUEUE_NUM  one-hot downstream word valid.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 invalid_pop_cnt  output  16  count of popped entries with valid bit 0.

Function
REQ-016 Queue q eligible SHALL be ~pifo_empty[q] & ~buffer_empty[q] & m_axis_tready[q].
REQ-017 FSM states IDLE, POP, LATCH, STREAM; only one queue served at a time.
REQ-018 IDLE: if any queue eligible, select by round-robin starting at last_served+1 (mod QUEUE_NUM), register sel, go POP; else stay.
REQ-019 POP: assert m_axis_ctl_pifo_out_en[sel] for exactly one cycle, go LATCH.
REQ-020 LATCH: capture s_axis_pifo_dout slice of sel; valid=1 -> rd_addr <= buffer_addr, go STREAM; valid=0 -> invalid_pop_cnt +1, last_served <= sel, go IDLE.
REQ-021 STREAM: m_axis_ctl_buffer_rd_en[sel] = m_axis_tvalid[sel] = m_axis_tready[sel] & ~s_axis_buffer_empty[sel], combinational; all other bits 0.
REQ-022 STREAM: word transferred with s_axis_buffer_tlast[sel]=1 -> last_served <= sel, go IDLE; next pop at earliest 1 cycle later.
REQ-023 STREAM with tready[sel]=0 or buffer empty SHALL hold state, enables 0, no timeout.
REQ-024 Eligibility changes of non-selected queues during POP/LATCH/STREAM SHALL be ignored.
REQ-025 invalid_pop_cnt SHALL saturate at 16'hFFFF.
REQ-026 Minimum per-packet overhead: 3 cycles (IDLE, POP, LATCH) before first word.

Reset
REQ-027 axis_reset high SHALL force immediately: state IDLE, sel 0, last_served QUEUE_NUM-1, rd_addr 0, invalid_pop_cnt 0, all enables/tvalid 0, busy 0.
REQ-028 Reset mid-STREAM SHALL abandon the packet without further reads; recovery is the buffer's responsibility.

Structure
REQ-029 Shared package SHALL hold state encodings (2-bit), PIFO field positions (VALID_POS 31, RANK 30:12, ADDR 11:0), and ADDR_WIDTH 12.
REQ-030 Round-robin selection SHALL be sub-module rr_arbiter_v0_1 (request vector, last grant in, one-hot grant + any out, combinational).

Verification
REQ-031 Queue 2 only eligible, entry {1,rank 5,addr 0x010}, 4-word packet, tready=1 -> pop pulse [2] at cycle 1, rd_addr 0x010, rd_en[2] 4 consecutive cycles, back to IDLE.
REQ-032 Queues 0,1,4 always eligible, 1-word packets -> service order 0,1,4,0,1,4.
REQ-033 tready[3] drops for 3 cycles mid-packet -> rd_en[3]/tvalid[3] 0 those cycles, state STREAM held, no words lost.
REQ-034 Popped entry valid=0 on queue 1 -> no buffer read, invalid_pop_cnt 0->1, next grant is queue 2 if eligible.
REQ-035 axis_reset asserted in STREAM between clock edges -> outputs 0 before next edge; after release queue 0 wins first.

Source files
------------

// File: rtl/dequeue_agent_v0_1_pkg.sv
// Shared definitions for the dequeue agent.
// Holds the FSM state encoding and the field layout of a root PIFO entry:
//   valid[31] | rank[30:12] | buffer_addr[11:0]
package dequeue_agent_v0_1_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StPop    = 2'd1,
    StLatch  = 2'd2,
    StStream = 2'd3
  } state_e;

  localparam int unsigned VALID_POS  = 31;
  localparam int unsigned RANK_MSB   = 30;
  localparam int unsigned RANK_LSB   = 12;
  localparam int unsigned ADDR_MSB   = 11;
  localparam int unsigned ADDR_LSB   = 0;
  localparam int unsigned ADDR_WIDTH = 12;

endpackage

// File: rtl/rr_arbiter_v0_1.sv
// Combinational round-robin arbiter.
// Searches the request vector starting one position after the last grant,
// wrapping modulo N, and grants the first requester found.
// Ports:
//   i_req   - request vector, one bit per requester
//   i_last  - index of the most recently served requester
//   o_grant - one-hot grant (all zero when no request)
//   o_any   - at least one request present
module rr_arbiter_v0_1 #(
  parameter int unsigned N    = 5,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_last,
  output logic [N-1:0]    o_grant,
  output logic            o_any
);

  always_comb begin
    logic        w_found;
    int unsigned w_idx;
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = (32'(i_last) + k) % N;
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/dequeue_agent_v0_1.sv
// Dequeue agent: picks one eligible output queue by round robin, pops its
// root PIFO entry, and streams the referenced packet out of the packet buffer
// until the end-of-packet word has been transferred.
// Ports:
//   axis_aclk / axis_reset    - clock, asynchronous active-high reset
//   s_axis_pifo_empty         - per-queue PIFO empty
//   s_axis_pifo_dout          - per-queue popped entry, valid one cycle after pop
//   s_axis_buffer_empty/tlast - per-queue packet buffer status
//   m_axis_tready             - per-queue downstream ready
//   m_axis_ctl_pifo_out_en    - one-hot PIFO pop pulse
//   m_axis_ctl_buffer_rd_en   - one-hot buffer read enable
//   m_axis_buffer_rd_addr     - start address of the packet in flight
//   m_axis_tvalid             - one-hot downstream word valid
//   busy                      - agent is serving a queue
//   invalid_pop_cnt           - saturating count of popped entries marked invalid
module dequeue_agent_v0_1
  import dequeue_agent_v0_1_pkg::*;
#(
  parameter int unsigned QUEUE_NUM  = 5,
  parameter int unsigned PIFO_WIDTH = 32
) (
  input  logic                            axis_aclk,
  input  logic                            axis_reset,
  input  logic [QUEUE_NUM-1:0]            s_axis_pifo_empty,
  input  logic [QUEUE_NUM*PIFO_WIDTH-1:0] s_axis_pifo_dout,
  input  logic [QUEUE_NUM-1:0]            s_axis_buffer_empty,
  input  logic [QUEUE_NUM-1:0]            s_axis_buffer_tlast,
  input  logic [QUEUE_NUM-1:0]            m_axis_tready,
  output logic [QUEUE_NUM-1:0]            m_axis_ctl_pifo_out_en,
  output logic [QUEUE_NUM-1:0]            m_axis_ctl_buffer_rd_en,
  output logic [ADDR_WIDTH-1:0]           m_axis_buffer_rd_addr,
  output logic [QUEUE_NUM-1:0]            m_axis_tvalid,
  output logic                            busy,
  output logic [15:0]                     invalid_pop_cnt
);

  localparam int unsigned SelW = (QUEUE_NUM > 1) ? $clog2(QUEUE_NUM) : 1;

  state_e                r_state, w_state_d;
  logic [SelW-1:0]       r_sel, r_last, w_grant_idx;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [15:0]           r_invalid_cnt;

  logic [QUEUE_NUM-1:0]  w_eligible, w_grant;
  logic                  w_any;
  logic [PIFO_WIDTH-1:0] w_entry;
  logic                  w_entry_valid;
  logic [ADDR_WIDTH-1:0] w_entry_addr;
  logic [RANK_MSB-RANK_LSB:0] w_unused_rank;
  logic                  w_word_xfer, w_pkt_done;
  logic                  w_load_sel, w_load_addr, w_count_invalid, w_update_last;

  assign w_eligible = ~s_axis_pifo_empty & ~s_axis_buffer_empty & m_axis_tready;

  rr_arbiter_v0_1 #(
    .N    (QUEUE_NUM),
    .IdxW (SelW)
  ) u_arbiter (
    .i_req   (w_eligible),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  always_comb begin
    w_grant_idx = '0;
    for (int unsigned q = 0; q < QUEUE_NUM; q++) begin
      if (w_grant[q]) w_grant_idx = SelW'(q);
    end
  end

  // Only the selected queue's slice matters; rank is consumed by the PIFO itself.
  assign w_entry       = s_axis_pifo_dout[32'(r_sel)*PIFO_WIDTH +: PIFO_WIDTH];
  assign w_entry_valid = w_entry[VALID_POS];
  assign w_entry_addr  = w_entry[ADDR_MSB:ADDR_LSB];
  assign w_unused_rank = w_entry[RANK_MSB:RANK_LSB];

  // A word moves only when the selected port is ready and the buffer has data.
  assign w_word_xfer = (r_state == StStream) & m_axis_tready[r_sel] &
                       ~s_axis_buffer_empty[r_sel];
  assign w_pkt_done  = w_word_xfer & s_axis_buffer_tlast[r_sel];

  always_comb begin
    w_state_d       = r_state;
    w_load_sel      = 1'b0;
    w_load_addr     = 1'b0;
    w_count_invalid = 1'b0;
    w_update_last   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_any) begin
          w_load_sel = 1'b1;
          w_state_d  = StPop;
        end
      end
      StPop: w_state_d = StLatch;
      StLatch: begin
        if (w_entry_valid) begin
          w_load_addr = 1'b1;
          w_state_d   = StStream;
        end else begin
          // Stale entry: skip it and let the arbiter move past this queue.
          w_count_invalid = 1'b1;
          w_update_last   = 1'b1;
          w_state_d       = StIdle;
        end
      end
      StStream: begin
        if (w_pkt_done) begin
          w_update_last = 1'b1;
          w_state_d     = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_state       <= StIdle;
      r_sel         <= '0;
      r_last        <= SelW'(QUEUE_NUM - 1);
      r_rd_addr     <= '0;
      r_invalid_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_load_sel)    r_sel     <= w_grant_idx;
      if (w_load_addr)   r_rd_addr <= w_entry_addr;
      if (w_update_last) r_last    <= r_sel;
      if (w_count_invalid && (r_invalid_cnt != 16'hFFFF)) begin
        r_invalid_cnt <= r_invalid_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    m_axis_ctl_pifo_out_en  = '0;
    m_axis_ctl_buffer_rd_en = '0;
    m_axis_tvalid           = '0;
    for (int unsigned q = 0; q < QUEUE_NUM; q++) begin
      if (r_sel == SelW'(q)) begin
        m_axis_ctl_pifo_out_en[q]  = (r_state == StPop);
        m_axis_ctl_buffer_rd_en[q] = w_word_xfer;
        m_axis_tvalid[q]           = w_word_xfer;
      end
    end
  end

  assign m_axis_buffer_rd_addr = r_rd_addr;
  assign busy                  = (r_state != StIdle);
  assign invalid_pop_cnt       = r_invalid_cnt;

endmodule
